expr_unit_arbiter: RTL and testbench
====================================

Name: expr_unit_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one multi-cycle arithmetic expression unit between NREQ requesters.
- The unit computes out = ((A/2)+B)*8 + (A-B/2)*4.
- Owns the start/done handshake with the unit, latches operands, and returns each result tagged with the requester id.
- Sits between the requesting blocks and the single shared expression-unit instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width.
- OP_WIDTH, WIDTH+4, result width.
- ID_W, 2, requester id width; must be ≥ clog2(NREQ).
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held with operands until the matching req_ready.
- req_a  in  NREQ*WIDTH  flattened operand A; slice k belongs to requester k.
- req_b  in  NREQ*WIDTH  flattened operand B.
- req_ready  out  NREQ  one-hot accept pulse.
- res_valid  out  1  result pulse.
- res_id  out  ID_W  requester id for res_data.
- res_data  out  OP_WIDTH  result.
- res_err  out  1  timeout flag, valid with res_valid; constant 0 without the optional feature.
- unit_start  out  1  one-cycle start pulse to the shared unit.
- unit_a  out  WIDTH  latched operand A to the unit.
- unit_b  out  WIDTH  latched operand B to the unit.
- unit_done  in  1  unit completion; first high cycle after unit_start is taken.
- unit_out  in  OP_WIDTH  unit result, valid while unit_done=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, res_valid, res_id, res_data, res_err, unit_start, unit_a, unit_b, busy.
  - An in-flight unit operation is abandoned.
  - A unit_done arriving after reset, while in IDLE, is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, select the winner: first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch winner id, A slice and B slice into grant_id, unit_a, unit_b; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): unit_start=1 and req_ready[grant_id]=1; go to WAIT.
  - Requester k deasserts or changes req_valid/operands only after seeing req_ready[k].
- WAIT:
  - Hold unit_a/unit_b stable.
  - On unit_done=1, register res_data<=unit_out, res_id<=grant_id; go to RESP.
  - unit_done high in the ISSUE cycle is ignored (stale).
- RESP (1 cycle): res_valid=1; rr_ptr <= (grant_id+1) mod NREQ; go to IDLE.
  - There is no result back-pressure: the consumer must take the result in this cycle.
- Outputs are Moore-decoded from registered state and latched fields: req_ready, unit_start, res_valid, busy.
- Fairness:
  - A requester held continuously valid waits at most NREQ-1 other grants.
  - Arrivals during ISSUE/WAIT/RESP are considered at the next IDLE.
- Throughput: minimum of 4 cycles per request plus unit latency. IDLE is always visited between requests (no back-to-back issue).
- Latency: req_valid sampled at edge N gives unit_start in cycle N+1. unit_done at edge M gives res_valid in cycle M+1.
- Widths:
  - res_data is passed through unmodified.
  - Operands are truncated or extended by nothing: the slices are exactly WIDTH bits.
  - rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: EXPR_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter is cleared on entry to WAIT.
  - If the count reaches TIMEOUT without unit_done, go to RESP with res_data=0 and res_err=1.
  - Arbitration proceeds normally afterwards.
  - unit_done in the same cycle as expiry wins: normal result, res_err=0.
- Without the macro: no counter is built, WAIT waits indefinitely, and res_err is tied to 0.

Test Plan:
- Single request: req0 A=10, B=4; unit model with 6-cycle latency -> unit_start one cycle after req_valid; res_valid with res_id=0, res_data=104, res_err=0; req_ready[0] pulses once.
- All four requesters valid continuously, distinct operands -> grant order 0,1,2,3,0; each result id matches its operands (e.g. req2 A=20, B=8: res_data=208).
- Round-robin wrap:
  - Step 1: only req3 valid, then 0 and 3 valid together -> grant order 3 then 0 (rr_ptr wrapped).
  - Step 2: repeat with req3 valid again -> grant order 0 then 3.
- Reset mid-WAIT: assert rst for 1 cycle while the unit is busy -> all outputs 0 immediately; the later stale unit_done produces no res_valid; the next request is granted to req0 first.
- Stale done: unit_done held high during the ISSUE cycle, then low, then high 3 cycles later with 55 -> res_data=55, not the stale value.
- With EXPR_ARB_TIMEOUT_EN and TIMEOUT=16: unit never responds -> res_valid 17±1 cycles after unit_start with res_err=1, res_data=0; the next queued request is then issued.

Source files
------------

// File: rtl/expr_unit_arbiter_if.sv
// Bus between the requesters, the shared expression unit and expr_unit_arbiter.
// Latency: none, this is wiring only.
// Backpressure: req_valid/req_ready per requester. Results have no backpressure (one-cycle res_valid).
interface expr_unit_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = WIDTH + 4,
    parameter int ID_W     = 2
);
    // requester side
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;

    // result side
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [OP_WIDTH-1:0]   res_data;
    logic                  res_err;

    // shared unit side
    logic                  unit_start;
    logic [WIDTH-1:0]      unit_a;
    logic [WIDTH-1:0]      unit_b;
    logic                  unit_done;
    logic [OP_WIDTH-1:0]   unit_out;

    logic                  busy;

    // arbiter view
    modport slave (
        input  req_valid, req_a, req_b, unit_done, unit_out,
        output req_ready, res_valid, res_id, res_data, res_err,
               unit_start, unit_a, unit_b, busy
    );

    // environment view: requesters, result consumer and the unit itself
    modport master (
        output req_valid, req_a, req_b, unit_done, unit_out,
        input  req_ready, res_valid, res_id, res_data, res_err,
               unit_start, unit_a, unit_b, busy
    );
endinterface

// File: rtl/expr_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one expression unit ((A/2+B)*8 + (A-B/2)*4) between NREQ requesters.
// Latency: unit_start 1 cycle after req_valid is sampled; res_valid 1 cycle after unit_done. That is 4 cycles plus unit latency per request.
// Backpressure: requesters hold req_valid until their req_ready pulse. There is no result backpressure. Optional watchdog: EXPR_ARB_TIMEOUT_EN.
module expr_unit_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = WIDTH + 4,
    parameter int ID_W     = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    expr_unit_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_id;
    logic [WIDTH-1:0]    unit_a_q;
    logic [WIDTH-1:0]    unit_b_q;
    logic [ID_W-1:0]     res_id_q;
    logic [OP_WIDTH-1:0] res_data_q;

    // Round-robin search state.
    // The request vector is doubled and rotated so that bit 0 is rr_ptr.
    // The first set bit is then the winner, and wrap-around falls out of the doubling.
    logic [2*NREQ-1:0]   rot_valid;
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    int                  win_sum;
    logic [WIDTH-1:0]    win_a;
    logic [WIDTH-1:0]    win_b;

    logic                timed_out;

    assign rot_valid = {bus.req_valid, bus.req_valid} >> rr_ptr;

    // Pick the first requesting index at or after rr_ptr, modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_sum   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && rot_valid[i]) begin
                win_found = 1'b1;
                win_sum   = int'(rr_ptr) + i;
            end
        end
        if (win_sum >= NREQ) begin
            win_sum = win_sum - NREQ;
        end
        win_id = ID_W'(win_sum);
    end

    // Operand slices of the winner. A shift plus truncation avoids a wide variable part-select.
    assign win_a = WIDTH'(bus.req_a >> (int'(win_id) * WIDTH));
    assign win_b = WIDTH'(bus.req_b >> (int'(win_id) * WIDTH));

`ifdef EXPR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             res_err_q;

    // Count cycles spent in WAIT.
    // The counter is zeroed during ISSUE so that it reads 0 in the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Expiry fires in the WAIT cycle that would be the TIMEOUT-th.
    // RESP then follows TIMEOUT+1 cycles after unit_start.
    assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Error flag for the pending result.
    // unit_done in the same cycle as expiry takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err_q <= 1'b0;
        end else if (state == WAIT) begin
            res_err_q <= timed_out && !bus.unit_done;
        end
    end

    assign bus.res_err = res_err_q;
`else
    logic unused_timeout;

    // No watchdog in this build: WAIT waits for unit_done indefinitely.
    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
    assign bus.res_err    = 1'b0;
`endif

    // Sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with operands and result latched along the way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id <= win_id;
                        unit_a_q <= win_a;
                        unit_b_q <= win_b;
                        state    <= ISSUE;
                    end
                end
                // unit_done seen here belongs to no request of ours and is dropped
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.unit_done) begin
                        res_data_q <= bus.unit_out;
                        res_id_q   <= grant_id;
                        state      <= RESP;
                    end else if (timed_out) begin
                        res_data_q <= '0;
                        res_id_q   <= grant_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state and the latched fields
    assign bus.req_ready  = (state == ISSUE) ? (ONE_HOT0 << grant_id) : '0;
    assign bus.unit_start = (state == ISSUE);
    assign bus.res_valid  = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.unit_a     = unit_a_q;
    assign bus.unit_b     = unit_b_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_data   = res_data_q;

endmodule

// File: tb/tb_expr_unit_arbiter.sv
// Directed bench for expr_unit_arbiter with a fixed-latency stand-in for the shared unit.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results are hand-computed: req0 A=10,B=4 -> 104; req1 A=6,B=2 -> 60; req2 A=20,B=8 -> 208; req3 A=100,B=30 -> 980.
module tb_expr_unit_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 32;
    localparam int OP_WIDTH = WIDTH + 4;
    localparam int ID_W     = 2;
    localparam int TIMEOUT  = 16;
    localparam int LAT      = 6;

    logic clk = 1'b0;
    logic rst;

    expr_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .ID_W(ID_W)) bus ();

    expr_unit_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Stand-in for the shared unit.
    // It latches operands on unit_start and answers LAT cycles later.
    // In manual mode the bench drives unit_done/unit_out directly.
    logic                model_en;
    logic                man_done;
    logic [OP_WIDTH-1:0] man_out;
    logic                auto_done = 1'b0;
    logic [OP_WIDTH-1:0] auto_out  = '0;
    logic [WIDTH-1:0]    lat_a, lat_b;
    int                  model_cnt = 0;

    function automatic logic [OP_WIDTH-1:0] unit_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [OP_WIDTH-1:0] ea, eb;
        ea = OP_WIDTH'(a);
        eb = OP_WIDTH'(b);
        return (((ea >> 1) + eb) << 3) + ((ea - (eb >> 1)) << 2);
    endfunction

    // Count down from each unit_start and pulse auto_done for one cycle
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (model_cnt > 0) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
                auto_done = 1'b1;
                auto_out  = unit_fn(lat_a, lat_b);
            end
        end
        if (bus.unit_start) begin
            model_cnt = LAT;
            lat_a     = bus.unit_a;
            lat_b     = bus.unit_b;
        end
    end

    assign bus.unit_done = model_en ? auto_done : man_done;
    assign bus.unit_out  = model_en ? auto_out  : man_out;

    // Log every grant and every result for order checks
    int gnt_log[$];
    int res_id_log[$];
    longint res_dat_log[$];

    always @(negedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_ready[k]) gnt_log.push_back(k);
        end
        if (bus.res_valid) begin
            res_id_log.push_back(int'(bus.res_id));
            res_dat_log.push_back(longint'(bus.res_data));
        end
    end

    function automatic longint exp_for(input int id);
        case (id)
            0:       return 104;
            1:       return 60;
            2:       return 208;
            default: return 980;
        endcase
    endfunction

    logic [NREQ-1:0] step_vec [8];

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.busy && cyc < budget);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic wait_grant(input int budget, output int ok);
        int cyc = 0;
        ok = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != '0) ok = 1;
        end
    endtask

    task automatic wait_res(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.res_valid && lat < budget);
    endtask

    // Start with req_valid=first; on the k-th grant switch req_valid to step_vec[k]
    task automatic run_seq(input string tag, input logic [NREQ-1:0] first, input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        bus.req_valid = first;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != '0) begin
                bus.req_valid = step_vec[seen];
                seen++;
            end
        end
        chk({tag, "_grants"}, seen, n);
        wait_idle(tag, budget);
    endtask

    // ord holds the expected grant ids, one per nibble, first grant in the lowest nibble
    task automatic check_log(input string tag, input int bg, input int br, input int n, input logic [31:0] ord);
        chk({tag, "_ngrant"}, gnt_log.size() - bg, n);
        chk({tag, "_nres"}, res_id_log.size() - br, n);
        for (int i = 0; i < n; i++) begin
            int id_exp = int'(ord[4*i +: 4]);
            if (bg + i < gnt_log.size())
                chk($sformatf("%s_gnt%0d", tag, i), gnt_log[bg + i], id_exp);
            if (br + i < res_id_log.size()) begin
                chk($sformatf("%s_id%0d", tag, i), res_id_log[br + i], id_exp);
                chk($sformatf("%s_dat%0d", tag, i), res_dat_log[br + i], exp_for(id_exp));
            end
        end
    endtask

    initial begin
        int bg, br, lat, ok;
        rst           = 1'b1;
        model_en      = 1'b1;
        man_done      = 1'b0;
        man_out       = '0;
        bus.req_valid = '0;
        bus.req_a     = {32'd100, 32'd20, 32'd6, 32'd10};
        bus.req_b     = {32'd30,  32'd8,  32'd2, 32'd4};
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_start", bus.unit_start, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_unit_a", bus.unit_a, 0);
        chk("rst_res_err", bus.res_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // single request: start next cycle, result LAT+1 cycles after start
        bg = gnt_log.size();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_start", bus.unit_start, 1);
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_unit_a", bus.unit_a, 10);
        chk("t1_unit_b", bus.unit_b, 4);
        bus.req_valid = '0;
        wait_res(30, lat);
        chk("t1_latency", lat, LAT + 1);
        chk("t1_res_id", bus.res_id, 0);
        chk("t1_res_data", bus.res_data, 104);
        chk("t1_res_err", bus.res_err, 0);
        wait_idle("t1", 10);
        chk("t1_ready_pulses", gnt_log.size() - bg, 1);

        // all four continuously valid: 0,1,2,3,0
        do_reset();
        bg = gnt_log.size();
        br = res_id_log.size();
        step_vec = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        run_seq("t2", 4'b1111, 5, 200);
        check_log("t2", bg, br, 5, 32'h0000_3210);

        // wrap: 3 alone, then 0 and 3 together -> 3, 0, 3
        do_reset();
        bg = gnt_log.size();
        br = res_id_log.size();
        step_vec = '{4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        run_seq("t3", 4'b1000, 3, 300);
        check_log("t3", bg, br, 3, 32'h0000_0303);

        // reset mid-WAIT: req1 leaves rr_ptr at 2, then req2 is abandoned by reset
        step_vec = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        run_seq("t4a", 4'b0010, 1, 100);
        bus.req_valid = 4'b0100;
        wait_grant(20, ok);
        chk("t4_grant2", ok, 1);
        bus.req_valid = '0;
        @(negedge clk);
        br = res_id_log.size();
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", bus.busy, 0);
        chk("t4_rst_start", bus.unit_start, 0);
        chk("t4_rst_unit_a", bus.unit_a, 0);
        chk("t4_rst_unit_b", bus.unit_b, 0);
        chk("t4_rst_res_data", bus.res_data, 0);
        chk("t4_rst_res_id", bus.res_id, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_stale_done_ignored", res_id_log.size() - br, 0);
        chk("t4_idle_after", bus.busy, 0);
        bg = gnt_log.size();
        br = res_id_log.size();
        step_vec[0] = 4'b0100;
        run_seq("t4b", 4'b0101, 2, 300);
        check_log("t4", bg, br, 2, 32'h0000_0020);

        // stale done during ISSUE is dropped; the later done with 55 is taken
        model_en      = 1'b0;
        man_out       = 36'd999;
        man_done      = 1'b1;
        bus.req_valid = 4'b0001;
        wait_grant(20, ok);
        chk("t5_grant", ok, 1);
        chk("t5_ready", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        man_done      = 1'b0;
        @(negedge clk);
        chk("t5_no_stale", bus.res_valid, 0);
        @(negedge clk);
        chk("t5_waiting", bus.busy, 1);
        @(negedge clk);
        man_out  = 36'd55;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("t5_res_valid", bus.res_valid, 1);
        chk("t5_res_data", bus.res_data, 55);
        chk("t5_res_id", bus.res_id, 0);
        chk("t5_res_err", bus.res_err, 0);
        wait_idle("t5", 20);
        repeat (8) @(negedge clk);

`ifdef EXPR_ARB_TIMEOUT_EN
        // unit never answers req1; req3 is queued behind it
        bus.req_valid = 4'b1010;
        wait_grant(20, ok);
        chk("t6_grant1", bus.req_ready, 4'b0010);
        bus.req_valid = 4'b1000;
        wait_res(40, lat);
        chk("t6_timeout_lat", lat, TIMEOUT + 1);
        chk("t6_res_err", bus.res_err, 1);
        chk("t6_res_data", bus.res_data, 0);
        chk("t6_res_id", bus.res_id, 1);
        model_en = 1'b1;
        wait_grant(20, ok);
        chk("t6_grant3", bus.req_ready, 4'b1000);
        bus.req_valid = '0;
        wait_res(30, lat);
        chk("t6_next_data", bus.res_data, 980);
        chk("t6_next_err", bus.res_err, 0);
        wait_idle("t6", 20);
`else
        // without the watchdog WAIT holds until unit_done, however late
        br = res_id_log.size();
        bus.req_valid = 4'b0010;
        wait_grant(20, ok);
        chk("t6_grant1", bus.req_ready, 4'b0010);
        bus.req_valid = '0;
        repeat (30) @(negedge clk);
        chk("t6_no_result", res_id_log.size() - br, 0);
        chk("t6_still_busy", bus.busy, 1);
        man_out  = 36'd77;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("t6_res_valid", bus.res_valid, 1);
        chk("t6_res_data", bus.res_data, 77);
        chk("t6_res_id", bus.res_id, 1);
        chk("t6_res_err", bus.res_err, 0);
        wait_idle("t6", 20);
        model_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000ns");
        $fatal(1);
    end

endmodule
